// File: rtl/uart_programmer.sv
// UART boot loader: receives little-endian bytes, packs them into 32-bit words and
// drives the instruction ROM / data memory programming port until done.
module uart_programmer #(
  parameter int CLK_FREQ     = 10000000,
  parameter int BAUD         = 625000,
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy_o,
  output logic        frame_err_o
);

  localparam int DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);
  localparam logic [14:0]      ADR_LAST = 15'h7FFF;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e            state_q, state_d;
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic [31:0]       dat_q, dat_d;
  logic [14:0]       adr_q, adr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;

  logic tick, sample, shift_en, byte_valid, stop_err, start_edge, timeout_hit;

  assign tick        = (div_cnt_q == DIV_LAST);
  assign start_edge  = (state_q == S_IDLE) && rx_prev_q && !rx_s2_q && !done_q;
  assign timeout_hit = (state_q == S_IDLE) && armed_q && !done_q && tick && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Timeout takes priority over a start edge arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_edge && !timeout_hit) state_d = S_START;
      S_START: if (sample) state_d = rx_s2_q ? S_IDLE : S_DATA;
      S_DATA:  if (sample && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (sample) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sample     = 1'b0;
    shift_en   = 1'b0;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    unique case (state_q)
      S_START: sample = tick && (os_cnt_q == OS_MID);
      S_DATA: begin
        sample   = tick && (os_cnt_q == OS_LAST);
        shift_en = sample;
      end
      S_STOP: begin
        sample     = tick && (os_cnt_q == OS_LAST);
        byte_valid = sample && rx_s2_q && !done_q;
        stop_err   = sample && !rx_s2_q && !done_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    dat_d      = dat_q;
    adr_d      = adr_q;
    to_cnt_d   = to_cnt_q;
    wen_d      = 1'b0;
    done_d     = done_q;
    busy_d     = busy_q;
    err_d      = err_q;
    armed_d    = armed_q;

    if (state_q == S_IDLE || sample) os_cnt_d = '0;
    else if (tick)                   os_cnt_d = os_cnt_q + 1'b1;

    if (state_q == S_IDLE) bit_idx_d = '0;
    else if (shift_en)     bit_idx_d = bit_idx_q + 1'b1;

    if (shift_en) shreg_d = {rx_s2_q, shreg_q[7:1]};

    if (byte_valid) begin
      armed_d    = 1'b1;
      byte_idx_d = byte_idx_q + 1'b1;
      unique case (byte_idx_q)
        2'd0: word_buf_d[7:0]   = shreg_q;
        2'd1: word_buf_d[15:8]  = shreg_q;
        2'd2: word_buf_d[23:16] = shreg_q;
        default: begin
          dat_d = {shreg_q, word_buf_q};
          wen_d = 1'b1;
        end
      endcase
    end

    if (stop_err) err_d = 1'b1;

    // The address advances after the strobe; the final slot ends the session instead.
    if (wen_q) begin
      if (adr_q == ADR_LAST) done_d = 1'b1;
      else                   adr_d  = adr_q + 1'b1;
    end

    if (state_q != S_IDLE || !armed_q || done_q || (rx_prev_q && !rx_s2_q)) to_cnt_d = '0;
    else if (tick)                                                         to_cnt_d = to_cnt_q + 1'b1;

    if (timeout_hit) begin
      done_d = 1'b1;
      if (byte_idx_q != 2'd0) err_d = 1'b1;
    end

    if (start_edge) busy_d = 1'b1;
    if (done_d)     busy_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      div_cnt_q  <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      dat_q      <= '0;
      adr_q      <= '0;
      to_cnt_q   <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      div_cnt_q  <= div_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
      dat_q      <= dat_d;
      adr_q      <= adr_d;
      to_cnt_q   <= to_cnt_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
    end
  end

  assign upg_wen_o   = wen_q;
  assign upg_adr_o   = adr_q;
  assign upg_dat_o   = dat_q;
  assign upg_done_o  = done_q;
  assign busy_o      = busy_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_uart_programmer.sv
// Scoreboard bench for uart_programmer: stimulus pushes expected writes, a monitor
// pops and compares on every upg_wen_o strobe.
module tb_uart_programmer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_i = 1'b1;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        busy_o;
  logic        frame_err_o;

  uart_programmer dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [14:0] adr;
    logic [31:0] dat;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_write(input logic [14:0] adr, input logic [31:0] dat);
    wr_t w;
    w.adr = adr;
    w.dat = dat;
    exp_q.push_back(w);
  endtask

  // Monitor: every strobe must match the oldest pending expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (upg_wen_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("no_write_expected", {31'b0, upg_wen_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_adr", {17'b0, upg_adr_o}, {17'b0, e.adr});
          check("wr_dat", upg_dat_o, e.dat);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (16) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (16) @(negedge clk);
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rx_i = 1'b1;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int limit, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (upg_done_o === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    check("done_within_bound", {31'b0, upg_done_o}, 32'd1);
  endtask

  initial begin
    int t_end;
    int t_done;
    int delta;

    // 1: reset values, single word
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wen", {31'b0, upg_wen_o}, 32'd0);
    check("rst_adr", {17'b0, upg_adr_o}, 32'd0);
    check("rst_dat", upg_dat_o, 32'd0);
    check("rst_done", {31'b0, upg_done_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_err", {31'b0, frame_err_o}, 32'd0);
    do_reset();
    expect_write(15'h0000, 32'h1234_5678);
    send_byte(8'h78, 1'b1);
    check("t1_busy", {31'b0, busy_o}, 32'd1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    check("t1_pending", exp_q.size(), 32'd0);
    check("t1_no_done", {31'b0, upg_done_o}, 32'd0);
    check("t1_err", {31'b0, frame_err_o}, 32'd0);

    // 2: two words then timeout
    do_reset();
    expect_write(15'h0000, 32'h0403_0201);
    expect_write(15'h0001, 32'h0807_0605);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    // The stop bit is sampled about nine clocks before send_byte returns.
    t_end = cyc - 9;
    wait_done(2000, t_done);
    delta = t_done - t_end;
    checks++;
    if (delta < 1008 || delta > 1040) begin
      errors++;
      $display("FAIL t2_done_latency: got %0d clks, expected 1024+-16", delta);
    end
    check("t2_pending", exp_q.size(), 32'd0);
    check("t2_busy_low", {31'b0, busy_o}, 32'd0);
    check("t2_adr", {17'b0, upg_adr_o}, 32'd2);

    // 3: short glitch is not a byte and does not arm the timeout
    do_reset();
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (1500) @(negedge clk);
    check("t3_no_done", {31'b0, upg_done_o}, 32'd0);
    check("t3_no_err", {31'b0, frame_err_o}, 32'd0);
    check("t3_adr", {17'b0, upg_adr_o}, 32'd0);

    // 4: bad stop bit is dropped and flagged, next bytes fill slot 0 onward
    do_reset();
    expect_write(15'h0000, 32'hDDCC_BBAA);
    send_byte(8'h55, 1'b0);
    check("t4_err", {31'b0, frame_err_o}, 32'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_pending", exp_q.size(), 32'd0);
    check("t4_err_sticky", {31'b0, frame_err_o}, 32'd1);

    // 5: partial word discarded at timeout, later bytes ignored
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    wait_done(2000, t_done);
    check("t5_err", {31'b0, frame_err_o}, 32'd1);
    check("t5_busy_low", {31'b0, busy_o}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'hF0 + 8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check("t5_done_hold", {31'b0, upg_done_o}, 32'd1);
    check("t5_busy_hold", {31'b0, busy_o}, 32'd0);
    check("t5_dat", upg_dat_o, 32'd0);

    // 6: reset during the second word, next session restarts at address 0
    do_reset();
    expect_write(15'h0000, 32'hCAFE_F00D);
    send_byte(8'h0D, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'hCA, 1'b1);
    rx_i = 1'b0;
    repeat (16 + 16 * 3 + 5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_wen", {31'b0, upg_wen_o}, 32'd0);
    check("t6_rst_adr", {17'b0, upg_adr_o}, 32'd0);
    check("t6_rst_dat", upg_dat_o, 32'd0);
    check("t6_rst_busy", {31'b0, busy_o}, 32'd0);
    check("t6_rst_done", {31'b0, upg_done_o}, 32'd0);
    check("t6_rst_err", {31'b0, frame_err_o}, 32'd0);
    rx_i = 1'b1;
    do_reset();
    repeat (20) @(negedge clk);
    expect_write(15'h0000, 32'hDEAD_BEEF);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_pending", exp_q.size(), 32'd0);
    check("t6_adr_after", {17'b0, upg_adr_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
